mc_alu: RTL and testbench

//  Multi-cycle, parametrised successor to the pipeline's single-cycle ALU. Single-cycle ops
//  (AND/OR/XOR/ADD/SUB/SLT) keep the existing 3-bit ALUOP encoding with 1-cycle registered latency.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/mc_alu_if.sv | 24 ++
 rtl/mc_alu_iter.sv | 84 ++++++++
 rtl/mc_alu.sv | 113 +++++++++++
 tb/tb_mc_alu.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 3-bit opcode encoding used by the control decoder
// and the state type of the multi-cycle sequencer.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mc_alu_if.sv
// Request/result bundle between the EX stage and mc_alu.
interface mc_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       ALUOP;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [WIDTH-1:0] OUT;
    logic [WIDTH-1:0] HI;
    logic             Zero;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUOP, In1, In2,
        input  OUT, HI, Zero, busy, done
    );

    modport slave (
        input  start, ALUOP, In1, In2,
        output OUT, HI, Zero, busy, done
    );
endinterface

// File: rtl/mc_alu_iter.sv
// Iterative MULTU/DIVU engine: one shift-add or restoring-subtract step per cycle,
// sharing a single adder and the {acc, q} shift register between both operations.
module mc_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             div_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   operand_a;
    logic [WIDTH:0]   addend;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        operand_a = div_q ? {acc_q, q_q[WIDTH-1]} : {1'b0, acc_q};
        addend    = div_q ? ~{1'b0, m_q} : {1'b0, m_q};
        // For divide, sum[WIDTH+1] is the no-borrow flag of (shifted remainder - divisor).
        sum       = {1'b0, operand_a} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, div_q};
        partial   = (q_q[0] ? sum[WIDTH:0] : {1'b0, acc_q});
        if (div_q) begin
            acc_step = sum[WIDTH+1] ? sum[WIDTH-1:0] : operand_a[WIDTH-1:0];
            q_step   = {q_q[WIDTH-2:0], sum[WIDTH+1]};
        end else begin
            acc_step = partial[WIDTH:1];
            q_step   = {partial[0], q_q[WIDTH-1:1]};
        end

        cnt_d = cnt_q;
        acc_d = acc_q;
        q_d   = q_q;
        m_d   = m_q;
        div_d = div_q;
        if (load) begin
            cnt_d = '0;
            acc_d = '0;
            q_d   = div_op ? a : b;
            m_d   = div_op ? b : a;
            div_d = div_op;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_step;
            q_d   = q_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            q_q   <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign hi_next = acc_step;
    assign lo_next = q_step;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MULTU/DIVU with HI/LO,
// sequenced by a two-state FSM that holds busy while the iteration runs.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MULDIV = 1
) (
    input  logic     clk,
    input  logic     rst,
    mc_alu_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             zpend_q, zpend_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic             operands_eq;
    logic             iter_load;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    always_comb begin
        alu_res = '0;
        unique case (bus.ALUOP)
            OP_AND:  alu_res = bus.In1 & bus.In2;
            OP_OR:   alu_res = bus.In1 | bus.In2;
            OP_ADD:  alu_res = bus.In1 + bus.In2;
            OP_SUB:  alu_res = bus.In1 - bus.In2;
            OP_XOR:  alu_res = bus.In1 ^ bus.In2;
            OP_SLT:  alu_res[0] = (bus.In1 < bus.In2);
            default: alu_res = '0;
        endcase
    end

    assign operands_eq = (bus.In1 == bus.In2);
    assign iter_load   = (state_q == IDLE) && bus.start && (MULDIV != 0) && is_iter_op(bus.ALUOP);

    mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (iter_load),
        .run     (state_q == RUN),
        .div_op  (bus.ALUOP == OP_DIVU),
        .a       (bus.In1),
        .b       (bus.In2),
        .last    (iter_last),
        .hi_next (iter_hi),
        .lo_next (iter_lo)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        zpend_d = zpend_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iter_load) begin
                    // Zero is held back so it only changes together with the result.
                    zpend_d = operands_eq;
                    state_d = RUN;
                end else if (bus.start) begin
                    out_d  = alu_res;
                    hi_d   = '0;
                    zero_d = operands_eq;
                    done_d = 1'b1;
                end
            end
            RUN: begin
                if (iter_last) begin
                    out_d   = iter_lo;
                    hi_d    = iter_hi;
                    zero_d  = zpend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            zpend_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            zpend_q <= zpend_d;
            done_q  <= done_d;
        end
    end

    assign bus.OUT  = out_q;
    assign bus.HI   = hi_q;
    assign bus.Zero = zero_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu at WIDTH=32 and WIDTH=8: expected results are queued
// when a request is driven and checked (value and cycle) when done pulses.
module tb_mc_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] out;
        logic [31:0] hi;
        logic        zero;
        int          due;
        logic [2:0]  op;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_alu_if #(.WIDTH(32)) b32 ();
    mc_alu_if #(.WIDTH(8))  b8 ();

    mc_alu #(.WIDTH(32), .MULDIV(1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    mc_alu #(.WIDTH(8),  .MULDIV(1)) dut8  (.clk(clk), .rst(rst), .bus(b8));

    exp_t q32[$];
    exp_t q8[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [63:0] mask, ra, rb, p, res, hi;
        mask = (64'd1 << w) - 64'd1;
        ra   = {32'd0, a} & mask;
        rb   = {32'd0, b} & mask;
        res  = 64'd0;
        hi   = 64'd0;
        case (op)
            OP_AND:  res = ra & rb;
            OP_OR:   res = ra | rb;
            OP_XOR:  res = ra ^ rb;
            OP_ADD:  res = (ra + rb) & mask;
            OP_SUB:  res = (ra - rb) & mask;
            OP_SLT:  res = (ra < rb) ? 64'd1 : 64'd0;
            OP_MULTU: begin
                p   = ra * rb;
                res = p & mask;
                hi  = (p >> w) & mask;
            end
            default: begin
                if (rb == 64'd0) begin
                    res = mask;
                    hi  = ra;
                end else begin
                    res = ra / rb;
                    hi  = ra % rb;
                end
            end
        endcase
        r.out  = res[31:0];
        r.hi   = hi[31:0];
        r.zero = (ra == rb);
        r.op   = op;
        r.due  = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (b32.done) begin
                vectors++;
                if (q32.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_done32 out=%h hi=%h cyc=%0d", b32.OUT, b32.HI, cyc);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    if (b32.OUT !== e.out || b32.HI !== e.hi || b32.Zero !== e.zero || cyc !== e.due) begin
                        miscompares++;
                        $display("FAIL result32 op=%0d out=%h want %h hi=%h want %h zero=%b want %b cyc=%0d want %0d",
                                 e.op, b32.OUT, e.out, b32.HI, e.hi, b32.Zero, e.zero, cyc, e.due);
                    end
                end
            end else if (q32.size() > 0 && q32[0].due < cyc) begin
                exp_t e;
                e = q32.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_done32 op=%0d done=0 want 1 at cyc %0d", e.op, e.due);
            end
            if (b8.done) begin
                vectors++;
                if (q8.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_done8 out=%h hi=%h cyc=%0d", b8.OUT, b8.HI, cyc);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    if (b8.OUT !== e.out[7:0] || b8.HI !== e.hi[7:0] || b8.Zero !== e.zero || cyc !== e.due) begin
                        miscompares++;
                        $display("FAIL result8 op=%0d out=%h want %h hi=%h want %h zero=%b want %b cyc=%0d want %0d",
                                 e.op, b8.OUT, e.out[7:0], b8.HI, e.hi[7:0], b8.Zero, e.zero, cyc, e.due);
                    end
                end
            end else if (q8.size() > 0 && q8[0].due < cyc) begin
                exp_t e;
                e = q8.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_done8 op=%0d done=0 want 1 at cyc %0d", e.op, e.due);
            end
        end
    end

    task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   guard;
        int   w;
        guard = 0;
        @(negedge clk);
        if (w8) b32.start = 1'b0;
        else    b8.start  = 1'b0;
        while ((w8 ? b8.busy : b32.busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout busy=1 want 0 within 200 cycles");
        end
        w     = w8 ? 8 : 32;
        e     = model(w, op, a, b);
        e.due = cyc + 1 + (is_iter_op(op) ? w : 0);
        if (w8) begin
            b8.start = 1'b1;
            b8.ALUOP = op;
            b8.In1   = a[7:0];
            b8.In2   = b[7:0];
            q8.push_back(e);
        end else begin
            b32.start = 1'b1;
            b32.ALUOP = op;
            b32.In1   = a;
            b32.In2   = b;
            q32.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        b32.start = 1'b0;
        b8.start  = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q32.size() != 0 || q8.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d want 0", q32.size() + q8.size());
            q32.delete();
            q8.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b32.start = 1'b0; b32.ALUOP = '0; b32.In1 = '0; b32.In2 = '0;
        b8.start  = 1'b0; b8.ALUOP  = '0; b8.In1  = '0; b8.In2  = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (b32.OUT !== 32'd0 || b32.HI !== 32'd0 || b32.Zero !== 1'b0 || b32.busy !== 1'b0 || b32.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset32 out=%h hi=%h zero=%b busy=%b done=%b want all 0",
                     b32.OUT, b32.HI, b32.Zero, b32.busy, b32.done);
        end
        vectors++;
        if (b8.OUT !== 8'd0 || b8.HI !== 8'd0 || b8.Zero !== 1'b0 || b8.busy !== 1'b0 || b8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset8 out=%h hi=%h zero=%b busy=%b done=%b want all 0",
                     b8.OUT, b8.HI, b8.Zero, b8.busy, b8.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c0;
        issue(0, OP_ADD, 32'd5, 32'd7);
        c0 = cyc;
        issue(0, OP_SUB, 32'd3, 32'd5);
        issue(0, OP_ADD, 32'h1234, 32'h1234);
        issue(0, OP_SLT, 32'd1, 32'd2);
        vectors++;
        if (cyc !== c0 + 3 || b32.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back cyc=%0d want %0d busy=%b want 0", cyc, c0 + 3, b32.busy);
        end
        idle();
        drain();
    endtask

    task automatic test_logic();
        issue(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(0, OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(0, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(0, OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        issue(0, OP_SUB, 32'd0, 32'd1);
        idle();
        drain();
    endtask

    task automatic test_multu();
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            vectors++;
            if (b32.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL multu_busy busy=%b want 1 at step %0d", b32.busy, i);
            end
            b32.start = 1'($urandom_range(0, 1));
            b32.ALUOP = 3'($urandom_range(0, 7));
            b32.In1   = $urandom;
            b32.In2   = $urandom;
        end
        idle();
        drain();
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(0, OP_MULTU, 32'd0, 32'h1234_5678);
        issue(0, OP_ADD, 32'd9, 32'd9);
        idle();
        drain();
    endtask

    task automatic test_divu();
        issue(0, OP_DIVU, 32'd100, 32'd7);
        issue(0, OP_DIVU, 32'd9, 32'd0);
        issue(0, OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        issue(0, OP_DIVU, 32'd5, 32'd5);
        issue(0, OP_DIVU, 32'd3, 32'hFFFF_FFFF);
        idle();
        drain();
    endtask

    task automatic test_reset_abort();
        issue(0, OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        b32.start = 1'b0;
        q32.delete();
        @(negedge clk);
        vectors++;
        if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.OUT !== 32'd0 || b32.HI !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort busy=%b done=%b out=%h hi=%h want all 0",
                     b32.busy, b32.done, b32.OUT, b32.HI);
        end
        rst = 1'b0;
        issue(0, OP_ADD, 32'd1, 32'd1);
        idle();
        drain();
    endtask

    task automatic test_random(input bit w8, input int n);
        logic [31:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = a;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(w8, op, a, b);
        end
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_logic();
        test_multu();
        test_divu();
        test_reset_abort();
        test_random(0, 600);
        test_random(1, 1200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
